// File: rtl/dma_pkg.sv
// Shared types and constants for the AXI4 write-DMA engine.
package dma_pkg;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExokay = 2'b01,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StAw,
        StW,
        StB,
        StDone
    } wr_state_e;

    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam int unsigned BOUNDARY_4K = 4096;

    // AWSIZE encoding for a beat of the given byte count (log2 of bytes).
    function automatic logic [2:0] axi_size(input int unsigned bytes);
        logic [2:0] code;
        code = '0;
        for (int i = 0; i < 8; i++) begin
            if (bytes == (32'd1 << i)) begin
                code = 3'(i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers; contents are flushed by reset.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy tracking; reset empties the FIFO.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrW'(1);
            if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/dma_write_stream.sv
// AXI4 write-DMA master: drains the input stream FIFO to memory as INCR bursts,
// splitting at 4 KB boundaries, one burst outstanding at a time.
module dma_write_stream
    import dma_pkg::*;
#(
    parameter int unsigned AXI_WIDTH_AD = 32,
    parameter int unsigned AXI_WIDTH_DA = 64,
    parameter int unsigned AXI_WIDTH_ID = 4,
    parameter int unsigned MAX_BURST    = 256,
    parameter int unsigned NUM_BITS     = 16,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start_i,
    input  logic [NUM_BITS-1:0]       num_beats_i,
    input  logic [AXI_WIDTH_AD-1:0]   start_addr_i,
    input  logic [AXI_WIDTH_DA-1:0]   s_data_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      m_axi_awvalid_o,
    input  logic                      m_axi_awready_i,
    output logic [AXI_WIDTH_AD-1:0]   m_axi_awaddr_o,
    output logic [7:0]                m_axi_awlen_o,
    output logic [2:0]                m_axi_awsize_o,
    output logic [1:0]                m_axi_awburst_o,
    output logic [AXI_WIDTH_ID-1:0]   m_axi_awid_o,
    output logic                      m_axi_wvalid_o,
    input  logic                      m_axi_wready_i,
    output logic [AXI_WIDTH_DA-1:0]   m_axi_wdata_o,
    output logic [AXI_WIDTH_DA/8-1:0] m_axi_wstrb_o,
    output logic                      m_axi_wlast_o,
    input  logic                      m_axi_bvalid_i,
    input  logic [1:0]                m_axi_bresp_i,
    input  logic [AXI_WIDTH_ID-1:0]   m_axi_bid_i,
    output logic                      m_axi_bready_o
);

    localparam int unsigned BPB     = AXI_WIDTH_DA / 8;
    localparam int unsigned SizeLog = $clog2(BPB);
    localparam int unsigned LenW    = 9;  // holds 1..256
    localparam logic [2:0]  AwSize  = axi_size(BPB);

    wr_state_e               state_q, state_d;
    logic [AXI_WIDTH_AD-1:0] addr_q, addr_d;
    logic [NUM_BITS-1:0]     rem_q, rem_d;
    logic [LenW-1:0]         len_q, len_d;
    logic [LenW-1:0]         beat_q, beat_d;
    logic                    err_q, err_d;
    logic                    ready_q;

    logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [AXI_WIDTH_DA-1:0] fifo_head;
    logic [12:0]             room_4k;
    logic                    w_last;
    logic                    unused_bid;

    assign unused_bid = ^m_axi_bid_i;

    // Ready is held low until the first clock after reset release.
    assign s_ready_o = ready_q && !fifo_full;
    assign fifo_push = s_valid_i && s_ready_o;
    assign fifo_pop  = m_axi_wvalid_o && m_axi_wready_i;

    sync_fifo #(
        .WIDTH(AXI_WIDTH_DA),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .push_i (fifo_push),
        .data_i (s_data_i),
        .pop_i  (fifo_pop),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .head_o (fifo_head)
    );

    // Beats left before the next 4 KB page; 13 bits so a page-aligned address yields 4096/BPB.
    assign room_4k = (13'(BOUNDARY_4K) - {1'b0, addr_q[11:0]}) >> SizeLog;
    assign w_last  = (beat_q == (len_q - LenW'(1)));

    assign m_axi_awaddr_o  = addr_q;
    assign m_axi_awlen_o   = 8'(len_q - LenW'(1));
    assign m_axi_awsize_o  = m_axi_awvalid_o ? AwSize : 3'b000;
    assign m_axi_awburst_o = m_axi_awvalid_o ? BURST_INCR : 2'b00;
    assign m_axi_awid_o    = '0;
    assign m_axi_wdata_o   = m_axi_wvalid_o ? fifo_head : '0;
    assign m_axi_wstrb_o   = {BPB{m_axi_wvalid_o}};
    assign m_axi_wlast_o   = m_axi_wvalid_o && w_last;
    assign err_o           = err_q;

    // Stream ready enable, set once reset has been released.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ready_q <= 1'b0;
        else       ready_q <= 1'b1;
    end

    // Job state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    // Burst sequencing: next state, register updates and AXI handshake outputs.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        len_d           = len_q;
        beat_d          = beat_q;
        err_d           = err_q;
        m_axi_awvalid_o = 1'b0;
        m_axi_wvalid_o  = 1'b0;
        m_axi_bready_o  = 1'b0;
        busy_o          = 1'b1;
        done_o          = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy_o = 1'b0;
                if (start_i) begin
                    addr_d = start_addr_i & ~AXI_WIDTH_AD'(BPB - 1);
                    rem_d  = num_beats_i;
                    err_d  = 1'b0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                beat_d = '0;
                if (rem_q == '0) begin
                    state_d = StDone;
                end else begin
                    // len = min(MAX_BURST, remaining, room_4k)
                    if (32'(rem_q) <= 32'(room_4k) && 32'(rem_q) <= 32'(MAX_BURST)) begin
                        len_d = LenW'(rem_q);
                    end else if (32'(room_4k) <= 32'(MAX_BURST)) begin
                        len_d = LenW'(room_4k);
                    end else begin
                        len_d = LenW'(MAX_BURST);
                    end
                    state_d = StAw;
                end
            end
            StAw: begin
                m_axi_awvalid_o = 1'b1;
                if (m_axi_awready_i) state_d = StW;
            end
            StW: begin
                m_axi_wvalid_o = !fifo_empty;
                if (!fifo_empty && m_axi_wready_i) begin
                    beat_d = beat_q + LenW'(1);
                    if (w_last) state_d = StB;
                end
            end
            StB: begin
                m_axi_bready_o = 1'b1;
                if (m_axi_bvalid_i) begin
                    addr_d = addr_q + (AXI_WIDTH_AD'(len_q) << SizeLog);
                    rem_d  = rem_q - NUM_BITS'(len_q);
                    if (axi_resp_e'(m_axi_bresp_i) != RespOkay) err_d = 1'b1;
                    state_d = StCalc;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
